// File: rtl/bp_sacc_spm_arbiter_pkg.sv
// Shared definitions for the streaming-accelerator scratchpad arbiter.
//   spm_els_gp     : default scratchpad depth in dwords
//   dword_width_gp : default data width
//   safe_clog2()   : index width that never collapses to zero bits
//   spm_req_s      : scratchpad request {w, addr, data} at the default sizes
package bp_sacc_spm_arbiter_pkg;

   localparam int spm_els_gp     = 20;
   localparam int dword_width_gp = 64;

   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic                                w;
      logic [safe_clog2(spm_els_gp)-1:0]   addr;
      logic [dword_width_gp-1:0]           data;
   } spm_req_s;

endpackage

// File: rtl/bp_sacc_rr_grant.sv
// Rotating-priority grant for the scratchpad arbiter.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i            : per-requester request valid
//   grant_o        : one-hot grant (at most one bit, only where v_i is set)
//   grant_id_o     : binary index of the granted requester
//   grant_v_o      : any grant this cycle
// A grant is always a handshake, so the last-granted pointer advances on
// every grant. Its reset value makes requester 0 the first winner.
module bp_sacc_rr_grant
   import bp_sacc_spm_arbiter_pkg::*;
#(
   parameter int reqs_p = 2
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [reqs_p-1:0]                  v_i,
   output logic [reqs_p-1:0]                  grant_o,
   output logic [safe_clog2(reqs_p)-1:0]      grant_id_o,
   output logic                               grant_v_o
);

   localparam int lg_lp = safe_clog2(reqs_p);

   logic [lg_lp-1:0] last_q, last_d;

   always_comb begin
      int idx;
      grant_o    = '0;
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      idx        = 0;
      // Search starts one past the last winner and wraps around.
      for (int i = 1; i <= reqs_p; i++) begin
         idx = (int'(last_q) + i) % reqs_p;
         if (!grant_v_o && !reset_i && v_i[idx]) begin
            grant_v_o      = 1'b1;
            grant_o[idx]   = 1'b1;
            grant_id_o     = idx[lg_lp-1:0];
         end
      end
      last_d = grant_v_o ? grant_id_o : last_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_q <= lg_lp'(reqs_p - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/bp_sacc_spm_arbiter.sv
// Round-robin arbiter sharing one 1rw synchronous scratchpad among
// reqs_p requesters, with 1-cycle read-data return and a write counter.
// Ports:
//   clk_i, reset_i     : clock, synchronous active-high reset
//   req_v_i/w_i        : per-requester valid and write flag
//   req_addr_i/data_i  : per-requester dword index and write data (slice i)
//   req_ready_and_o    : one-hot grant, combinational
//   resp_v_o/data_o    : one-hot read valid and shared read data
//   spm_*_o, spm_data_i: scratchpad access port (read data one cycle later)
//   wr_cnt_clear_i     : clear the write counter (a same-cycle write counts)
//   wr_cnt_o           : number of completed scratchpad writes
//   oob_err_o          : sticky out-of-range flag (BP_SACC_SPM_ARB_BOUNDS_EN)
// Optional feature macro: BP_SACC_SPM_ARB_BOUNDS_EN. When defined, requests
// at addr >= els_p are granted but never reach the scratchpad; reads return 0.
module bp_sacc_spm_arbiter
   import bp_sacc_spm_arbiter_pkg::*;
#(
   parameter int reqs_p        = 2,
   parameter int els_p         = spm_els_gp,
   parameter int width_p       = dword_width_gp,
   localparam int addr_width_lp = safe_clog2(els_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [reqs_p-1:0]                 req_v_i,
   input  logic [reqs_p-1:0]                 req_w_i,
   input  logic [reqs_p*addr_width_lp-1:0]   req_addr_i,
   input  logic [reqs_p*width_p-1:0]         req_data_i,
   output logic [reqs_p-1:0]                 req_ready_and_o,
   output logic [reqs_p-1:0]                 resp_v_o,
   output logic [width_p-1:0]                resp_data_o,
   output logic                              spm_v_o,
   output logic                              spm_w_o,
   output logic [addr_width_lp-1:0]          spm_addr_o,
   output logic [width_p-1:0]                spm_data_o,
   input  logic [width_p-1:0]                spm_data_i,
   input  logic                              wr_cnt_clear_i,
   output logic [width_p-1:0]                wr_cnt_o
`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
   ,
   output logic                              oob_err_o
`endif
);

   localparam int lg_lp = safe_clog2(reqs_p);

   typedef struct packed {
      logic                      w;
      logic [addr_width_lp-1:0]  addr;
      logic [width_p-1:0]        data;
   } req_s;

   logic [reqs_p-1:0] grant;
   logic [lg_lp-1:0]  grant_id;
   logic              grant_v;
   req_s              sel;
   logic              oob;
   logic              wr_inc;
   logic              rd_v_q, rd_v_d;
   logic [reqs_p-1:0] rd_id_q, rd_id_d;
   logic              rd_oob_q, rd_oob_d;
   logic [width_p-1:0] wr_cnt_q, wr_cnt_d;

   bp_sacc_rr_grant #(.reqs_p(reqs_p)) u_rr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .v_i        (req_v_i),
      .grant_o    (grant),
      .grant_id_o (grant_id),
      .grant_v_o  (grant_v)
   );

   assign req_ready_and_o = grant;

   always_comb begin
      sel.w    = req_w_i[grant_id];
      sel.addr = req_addr_i[grant_id*addr_width_lp +: addr_width_lp];
      sel.data = req_data_i[grant_id*width_p +: width_p];
   end

`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
   // Zero-extended compare so a power-of-two els_p cannot alias to 0.
   assign oob = int'(sel.addr) >= els_p;
`else
   assign oob = 1'b0;
`endif

   assign spm_v_o    = grant_v & ~oob;
   assign spm_w_o    = sel.w;
   assign spm_addr_o = sel.addr;
   assign spm_data_o = sel.data;

   // Read-response pipeline register; id and oob travel with rd_v.
   assign rd_v_d   = grant_v & ~sel.w;
   assign rd_id_d  = grant;
   assign rd_oob_d = oob;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_v_q <= 1'b0;
      end else begin
         rd_v_q <= rd_v_d;
      end
      rd_id_q  <= rd_id_d;
      rd_oob_q <= rd_oob_d;
   end

   // Gating with reset_i drops a response whose handshake preceded reset.
   assign resp_v_o    = (rd_v_q && !reset_i) ? rd_id_q : '0;
   assign resp_data_o = rd_oob_q ? '0 : spm_data_i;

   // Write counter: clear takes effect first, then a same-cycle write counts.
   assign wr_inc = grant_v & sel.w & ~oob;

   always_comb begin
      wr_cnt_d = wr_cnt_clear_i ? '0 : wr_cnt_q;
      if (wr_inc) wr_cnt_d = wr_cnt_d + width_p'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign wr_cnt_o = wr_cnt_q;

`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
   logic oob_err_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         oob_err_q <= 1'b0;
      end else if (grant_v && oob) begin
         oob_err_q <= 1'b1;
      end
   end

   assign oob_err_o = oob_err_q;
`endif

endmodule

// File: tb/tb_bp_sacc_spm_arbiter.sv
module tb_bp_sacc_spm_arbiter;

   localparam int REQS = 2;
   localparam int ELS  = 20;
   localparam int W    = 64;
   localparam int AW   = 5;

   logic              clk = 1'b0;
   logic              reset_i;
   logic [REQS-1:0]   req_v_i, req_w_i;
   logic [REQS*AW-1:0] req_addr_i;
   logic [REQS*W-1:0] req_data_i;
   logic [REQS-1:0]   req_ready_and_o, resp_v_o;
   logic [W-1:0]      resp_data_o;
   logic              spm_v_o, spm_w_o;
   logic [AW-1:0]     spm_addr_o;
   logic [W-1:0]      spm_data_o;
   logic [W-1:0]      spm_data_i;
   logic              wr_cnt_clear_i;
   logic [W-1:0]      wr_cnt_o;
`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
   logic              oob_err_o;
`endif

   always #5 clk = ~clk;

   bp_sacc_spm_arbiter #(.reqs_p(REQS), .els_p(ELS), .width_p(W)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .req_v_i         (req_v_i),
      .req_w_i         (req_w_i),
      .req_addr_i      (req_addr_i),
      .req_data_i      (req_data_i),
      .req_ready_and_o (req_ready_and_o),
      .resp_v_o        (resp_v_o),
      .resp_data_o     (resp_data_o),
      .spm_v_o         (spm_v_o),
      .spm_w_o         (spm_w_o),
      .spm_addr_o      (spm_addr_o),
      .spm_data_o      (spm_data_o),
      .spm_data_i      (spm_data_i),
      .wr_cnt_clear_i  (wr_cnt_clear_i),
      .wr_cnt_o        (wr_cnt_o)
`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
      ,
      .oob_err_o       (oob_err_o)
`endif
   );

   // Scratchpad environment: synchronous 1rw memory driven by the DUT.
   logic [W-1:0] spm_mem [32];
   always @(posedge clk) begin
      if (spm_v_o) begin
         if (spm_w_o) spm_mem[spm_addr_o] <= spm_data_o;
         else         spm_data_i <= spm_mem[spm_addr_o];
      end
   end

   // Reference model state
   typedef struct {
      logic [REQS-1:0] id;
      logic [W-1:0]    data;
   } resp_t;

   resp_t        exp_q[$];
   logic [W-1:0] ref_mem [32];
   int           last_m;
   logic [W-1:0] wcnt_m;
   logic         oob_m;
   logic         model_ok;
   int           n_checks;
   int           n_fail;

   task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic is_oob(input logic [AW-1:0] a);
`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
      return int'(a) >= ELS;
`else
      return 1'b0;
`endif
   endfunction

   task automatic step(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic clr, input logic rst);
      logic [REQS-1:0] eg;
      int              gid;
      logic [AW-1:0]   ga;
      logic [W-1:0]    gd;
      logic            gw, go;
      resp_t           r;
      logic [REQS-1:0] er;

      reset_i        = rst;
      req_v_i        = v;
      req_w_i        = w;
      req_addr_i     = {a1, a0};
      req_data_i     = {d1, d0};
      wr_cnt_clear_i = clr;
      #4;

      // expected grant
      eg  = '0;
      gid = 0;
      if (!rst) begin
         for (int i = 1; i <= REQS; i++) begin
            int k;
            k = (last_m + i) % REQS;
            if (eg == '0 && v[k]) begin
               eg[k] = 1'b1;
               gid   = k;
            end
         end
      end
      ga = (gid == 0) ? a0 : a1;
      gd = (gid == 0) ? d0 : d1;
      gw = w[gid];
      go = is_oob(ga);

      check_val("grant", W'(req_ready_and_o), W'(eg));
      check_val("spm_v", W'(spm_v_o), W'((eg != '0) && !go));
      if (eg != '0 && !go) begin
         check_val("spm_w", W'(spm_w_o), W'(gw));
         check_val("spm_addr", W'(spm_addr_o), W'(ga));
         if (gw) check_val("spm_data", spm_data_o, gd);
      end

      // expected response from the scoreboard
      er = '0;
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         if (!rst) er = r.id;
      end
      check_val("resp_v", W'(resp_v_o), W'(er));
      if (er != '0) check_val("resp_data", resp_data_o, r.data);

      if (model_ok) begin
         check_val("wr_cnt", wr_cnt_o, wcnt_m);
`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
         check_val("oob_err", W'(oob_err_o), W'(oob_m));
`endif
      end

      // advance the model
      if (rst) begin
         last_m   = REQS - 1;
         wcnt_m   = '0;
         oob_m    = 1'b0;
         model_ok = 1'b1;
         exp_q.delete();
      end else begin
         if (clr) wcnt_m = '0;
         if (eg != '0) begin
            last_m = gid;
            if (go) oob_m = 1'b1;
            if (gw) begin
               if (!go) begin
                  ref_mem[ga] = gd;
                  wcnt_m = wcnt_m + 1;
               end
            end else begin
               r.id   = eg;
               r.data = go ? '0 : ref_mem[ga];
               exp_q.push_back(r);
            end
         end
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_ok = 1'b0;
      last_m   = REQS - 1;
      wcnt_m   = '0;
      oob_m    = 1'b0;
      for (int i = 0; i < 32; i++) begin
         spm_mem[i] = '0;
         ref_mem[i] = '0;
      end
      spm_data_i = '0;
      @(posedge clk);
      #1;

      // Reset with requests asserted: no grants may appear.
      step(2'b11, 2'b00, 5'd1, 5'd2, '0, '0, 1'b0, 1'b1);
      step(2'b11, 2'b00, 5'd1, 5'd2, '0, '0, 1'b0, 1'b1);
      idle();

      // req0 write then read addr 3
      step(2'b01, 2'b01, 5'd3, 5'd0, 64'hDEAD_BEEF, '0, 1'b0, 1'b0);
      step(2'b01, 2'b00, 5'd3, 5'd0, '0, '0, 1'b0, 1'b0);
      idle();
      step(2'b10, 2'b10, 5'd0, 5'd5, '0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

      // Both requesters reading for 4 cycles: alternating grants.
      for (int i = 0; i < 4; i++)
         step(2'b11, 2'b00, 5'd3, 5'd5, '0, '0, 1'b0, 1'b0);
      idle();

      // req1 alone three times, then req0 alone.
      for (int i = 0; i < 3; i++)
         step(2'b10, 2'b00, 5'd0, 5'd3, '0, '0, 1'b0, 1'b0);
      step(2'b01, 2'b00, 5'd5, 5'd0, '0, '0, 1'b0, 1'b0);
      idle();

      // Bring the write count to 5, then clear with and without a write.
      for (int i = 0; i < 3; i++)
         step(2'b01, 2'b01, 5'(i + 7), 5'd0, 64'(i + 100), '0, 1'b0, 1'b0);
      step(2'b01, 2'b01, 5'd19, 5'd0, 64'hFFFF_0000_FFFF_0000, '0, 1'b1, 1'b0);
      step(2'b00, 2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
      idle();

      // Read handshake followed immediately by reset drops the response.
      step(2'b01, 2'b00, 5'd3, 5'd0, '0, '0, 1'b0, 1'b0);
      step(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b1);
      idle();
      step(2'b11, 2'b00, 5'd19, 5'd3, '0, '0, 1'b0, 1'b0);
      idle();

`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
      // Out-of-range read and write: granted, no scratchpad access.
      step(2'b01, 2'b00, 5'd20, 5'd0, '0, '0, 1'b0, 1'b0);
      step(2'b10, 2'b10, 5'd0, 5'd25, '0, 64'h55, 1'b0, 1'b0);
      idle();
      idle();
      step(2'b00, 2'b00, '0, '0, '0, '0, 1'b0, 1'b1);
      idle();
`endif

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         logic [AW-1:0] ra0, ra1;
`ifdef BP_SACC_SPM_ARB_BOUNDS_EN
         ra0 = AW'($urandom_range(0, 23));
         ra1 = AW'($urandom_range(0, 23));
`else
         ra0 = AW'($urandom_range(0, ELS - 1));
         ra1 = AW'($urandom_range(0, ELS - 1));
`endif
         step(2'($urandom), 2'($urandom), ra0, ra1,
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0), 1'b0);
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
